// File: rtl/ice40_himax_pkg.sv
// Shared types and constants for the HiMax camera emulator and its clock-gating controller.
package ice40_himax_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StVsync,
    StVblank,
    StActive,
    StHblank
  } cam_state_e;

  typedef enum logic [1:0] {
    PatRamp    = 2'd0,
    PatBars    = 2'd1,
    PatConst   = 2'd2,
    PatChecker = 2'd3
  } pat_sel_e;

  localparam int unsigned XyW       = 12;
  localparam int unsigned CntW      = 22;
  localparam int unsigned FrameCntW = 16;

  // Clock-gating controller measures the vsync period with a counter of the same width.
  typedef enum logic [1:0] {
    CgRun,
    CgDrain,
    CgGated,
    CgWake
  } cg_state_e;

  localparam int unsigned CgPeriodW = CntW;

endpackage

// File: rtl/ice40_himax_cam_emu_if.sv
// Camera-side parallel video bus: frame sync, line valid and 8-bit pixel data.
interface ice40_himax_cam_emu_if;
  logic       vsync;
  logic       hsync;
  logic [7:0] data;

  modport master (output vsync, output hsync, output data);
  modport slave  (input vsync, input hsync, input data);
endinterface

// File: rtl/ice40_himax_pat_gen.sv
// Combinational test-pattern generator; the parent registers the result.
module ice40_himax_pat_gen
  import ice40_himax_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 324
) (
  input  logic [XyW-1:0] x_i,
  input  logic [7:0]     y_i,
  input  logic [7:0]     frame_lsb_i,
  input  pat_sel_e       sel_i,
  input  logic [7:0]     const_i,
  output logic [7:0]     pix_o
);

  logic [14:0] x8;
  logic [14:0] quot;
  logic [2:0]  bar;

  always_comb begin
    x8    = {x_i, 3'b000};
    quot  = x8 / 15'(H_ACTIVE);
    bar   = (quot > 15'd7) ? 3'd7 : quot[2:0];
    pix_o = 8'h00;
    unique case (sel_i)
      PatRamp:    pix_o = x_i[7:0] + y_i + frame_lsb_i;
      PatBars:    pix_o = {bar, 5'b00000};
      PatConst:   pix_o = const_i;
      PatChecker: pix_o = (x_i[3] ^ y_i[3]) ? 8'hFF : 8'h00;
      default:    pix_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/ice40_himax_cam_emu.sv
// HiMax-style camera emulator: frame timing FSM with registered sync, data and status outputs.
module ice40_himax_cam_emu
  import ice40_himax_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 324,
  parameter int unsigned H_BLANK  = 76,
  parameter int unsigned V_ACTIVE = 324,
  parameter int unsigned VS_LEN   = 16,
  parameter int unsigned VB_LEN   = 4096
) (
  input  logic                  i_pclk_in,
  input  logic                  resetn,
  input  logic                  i_en,
  input  logic [1:0]            i_pat_sel,
  input  logic [7:0]            i_const,
  ice40_himax_cam_emu_if.master o_cam,
  output logic [15:0]           o_frame_cnt,
  output logic                  o_busy
);

  cam_state_e           state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [XyW-1:0]       x_q, x_d, y_q, y_d;
  logic [FrameCntW-1:0] frame_cnt_q, frame_cnt_d;
  pat_sel_e             sel_q, sel_d;
  logic [7:0]           const_q, const_d;
  logic                 vsync_q, vsync_d, hsync_q, hsync_d, busy_q, busy_d;
  logic [7:0]           data_q, data_d;
  logic [7:0]           pix;

  ice40_himax_pat_gen #(
    .H_ACTIVE(H_ACTIVE)
  ) u_pat_gen (
    .x_i        (x_q),
    .y_i        (y_q[7:0]),
    .frame_lsb_i(frame_cnt_q[7:0]),
    .sel_i      (sel_q),
    .const_i    (const_q),
    .pix_o      (pix)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    frame_cnt_d = frame_cnt_q;
    sel_d       = sel_q;
    const_d     = const_q;
    unique case (state_q)
      StIdle: begin
        if (i_en) begin
          state_d = StVsync;
          cnt_d   = '0;
        end
      end
      StVsync: begin
        if (cnt_q == CntW'(VS_LEN - 1)) begin
          state_d = StVblank;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 22'd1;
        end
      end
      StVblank: begin
        // Pattern controls are frozen here for the whole frame.
        if (cnt_q == CntW'(VB_LEN - 1)) begin
          state_d = StActive;
          cnt_d   = '0;
          x_d     = '0;
          y_d     = '0;
          sel_d   = pat_sel_e'(i_pat_sel);
          const_d = i_const;
        end else begin
          cnt_d = cnt_q + 22'd1;
        end
      end
      StActive: begin
        if (x_q == XyW'(H_ACTIVE - 1)) begin
          state_d = StHblank;
          cnt_d   = '0;
        end else begin
          x_d = x_q + 12'd1;
        end
      end
      StHblank: begin
        if (cnt_q == CntW'(H_BLANK - 1)) begin
          cnt_d = '0;
          if (y_q < XyW'(V_ACTIVE - 1)) begin
            state_d = StActive;
            x_d     = '0;
            y_d     = y_q + 12'd1;
          end else begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = i_en ? StVsync : StIdle;
          end
        end else begin
          cnt_d = cnt_q + 22'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sync/data outputs are a registered decode of the current state (one-cycle lag).
  always_comb begin
    vsync_d = (state_q == StVsync);
    hsync_d = (state_q == StActive);
    data_d  = hsync_d ? pix : 8'h00;
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge i_pclk_in or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      frame_cnt_q <= '0;
      sel_q       <= PatRamp;
      const_q     <= '0;
      vsync_q     <= 1'b0;
      hsync_q     <= 1'b0;
      data_q      <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      frame_cnt_q <= frame_cnt_d;
      sel_q       <= sel_d;
      const_q     <= const_d;
      vsync_q     <= vsync_d;
      hsync_q     <= hsync_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
    end
  end

  assign o_cam.vsync = vsync_q;
  assign o_cam.hsync = hsync_q;
  assign o_cam.data  = data_q;
  assign o_frame_cnt = frame_cnt_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_ice40_himax_cam_emu.sv
// Self-checking bench: per-cycle comparison against a frame-position model plus directed scenarios.
module tb_ice40_himax_cam_emu;

  localparam int HA = 4;
  localparam int HB = 2;
  localparam int VA = 3;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int PERIOD = VS + VB + VA * (HA + HB);

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic [7:0]  cst = 8'd0;
  logic [15:0] frame_cnt;
  logic        busy;

  ice40_himax_cam_emu_if cam_if ();

  ice40_himax_cam_emu #(
    .H_ACTIVE(HA),
    .H_BLANK (HB),
    .V_ACTIVE(VA),
    .VS_LEN  (VS),
    .VB_LEN  (VB)
  ) dut (
    .i_pclk_in  (clk),
    .resetn     (rst_n),
    .i_en       (en),
    .i_pat_sel  (sel),
    .i_const    (cst),
    .o_cam      (cam_if),
    .o_frame_cnt(frame_cnt),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  // Model: m_t is the frame position (cycles since the enable-sampling edge) of the state.
  bit m_run;
  int m_t, m_fc, m_sel, m_const;

  int         rises[$];
  logic [7:0] act_q[$];
  logic       prev_vs = 1'b0;

  function automatic int exp_pix(int s, int c, int x, int y, int fc);
    int b;
    case (s)
      0: return (x + y + fc) % 256;
      1: begin
        b = (8 * x) / HA;
        if (b > 7) b = 7;
        return 32 * b;
      end
      2: return c;
      default: return ((((x / 8) % 2) ^ ((y / 8) % 2)) != 0) ? 255 : 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    int ev, eh, ed, q, ln, col;
    ev = 0;
    eh = 0;
    ed = 0;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      m_run = 0;
      m_fc  = 0;
    end else begin
      if (m_run) begin
        ev = (m_t < VS) ? 1 : 0;
        q  = m_t - VS - VB;
        if (q >= 0) begin
          ln  = q / (HA + HB);
          col = q % (HA + HB);
          if (col < HA) begin
            eh = 1;
            ed = exp_pix(m_sel, m_const, col, ln, m_fc);
          end
        end
      end
      if (!m_run) begin
        if (en) begin
          m_run = 1;
          m_t   = 0;
        end
      end else begin
        m_t++;
        if (m_t == VS + VB) begin
          m_sel   = int'(sel);
          m_const = int'(cst);
        end
        if (m_t == PERIOD) begin
          m_fc = (m_fc + 1) % 65536;
          if (en) m_t = 0;
          else m_run = 0;
        end
      end
    end
    #1;
    chk("vsync", cam_if.vsync, ev);
    chk("hsync", cam_if.hsync, eh);
    chk("data", cam_if.data, ed);
    chk("frame_cnt", frame_cnt, m_fc);
    chk("busy", busy, m_run ? 1 : 0);
    if (cam_if.vsync && !prev_vs) rises.push_back(cyc);
    prev_vs = cam_if.vsync;
    if (cam_if.hsync) act_q.push_back(cam_if.data);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_pos(input int target, input int maxc);
    int k;
    k = 0;
    while (!(m_run && m_t == target) && k < maxc) begin
      tick();
      k++;
    end
    chk("wait_bound", (k < maxc) ? 1 : 0, 1);
  endtask

  initial begin
    int c0, nr;
    m_run = 0; m_t = 0; m_fc = 0; m_sel = 0; m_const = 0;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_vsync", cam_if.vsync, 0);
    chk("rst_hsync", cam_if.hsync, 0);
    chk("rst_data", cam_if.data, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_busy", busy, 0);
    run(3);

    // Continuous frames, ramp pattern
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    sel   = 2'd0;
    c0    = cyc;
    run(PERIOD + 1);
    chk("fc_after_frame0", frame_cnt, 1);
    run(PERIOD);
    chk("first_vsync_cycle", rises[0], c0 + 2);
    chk("vsync_spacing", rises[1] - rises[0], PERIOD);
    for (int k = 0; k < 4; k++) begin
      chk("f0_line1_px", act_q[4+k], k + 1);
      chk("f1_line0_px", act_q[12+k], k + 1);
    end

    // Enable dropped during line 1: frame completes, then idle
    wait_pos(VS + VB + (HA + HB) + 1, 2 * PERIOD);
    en = 1'b0;
    nr = rises.size();
    run(PERIOD + 5);
    chk("stop_frame_cnt", frame_cnt, 3);
    chk("stop_busy", busy, 0);
    chk("stop_no_vsync", rises.size(), nr);

    // Constant pattern held despite a mid-frame select change
    sel = 2'd2;
    cst = 8'hA5;
    en  = 1'b1;
    act_q.delete();
    wait_pos(VS + VB + 2, 2 * PERIOD);
    sel = 2'd0;
    cst = 8'h3C;
    run(PERIOD - (VS + VB + 2));
    for (int k = 0; k < HA * VA; k++) chk("const_frame_px", act_q[k], 8'hA5);
    run(PERIOD);

    // Asynchronous reset during active video
    wait_pos(VS + VB + 1, 2 * PERIOD);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_vsync", cam_if.vsync, 0);
    chk("arst_hsync", cam_if.hsync, 0);
    chk("arst_data", cam_if.data, 0);
    chk("arst_frame_cnt", frame_cnt, 0);
    chk("arst_busy", busy, 0);
    m_run = 0;
    m_fc  = 0;
    @(negedge clk);
    rst_n = 1'b1;
    c0    = cyc;
    run(4);
    chk("restart_vsync_cycle", rises[$], c0 + 2);
    run(PERIOD);

    // Frame counter wrap
    wait_pos(1, 2 * PERIOD);
    force dut.frame_cnt_q = 16'hFFFF;
    m_fc = 65535;
    tick();
    #3 release dut.frame_cnt_q;
    run(PERIOD);
    chk("fc_wrap", frame_cnt, 0);

    // Randomized controls
    repeat (600) begin
      if ($urandom_range(0, 19) == 0) sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) cst = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 99) == 0) en = ~en;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
